hv_cmdq_param: RTL and testbench

Parametrised, multi-slot successor to the HV command queue. It accepts fixed-size CDBs as a burst of `CMD_IO_WIDTH` beats and checks their XOR checksum. It holds each CDB in a tag-indexed slot with a per-slot status, and issues queued CDBs to the command-processing module in arrival order. It also answers host status queries and frees slots when a command completes. The block sits between the host command interface and the command-processing/TBM logic.

---
 rtl/hv_cmdq_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_hv_cmdq_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_cmdq_param.sv
// Multi-slot HV command queue: assembles CDB bursts into tag-indexed slots, issues them in arrival order, answers status queries.
// Optional checksum verification is enabled with `define HV_CMDQ_CHECKSUM_EN.
module hv_cmdq_param #(
  parameter int CMD_IO_WIDTH = 64,
  parameter int CDB_WIDTH    = 256,
  parameter int DEPTH        = 8,
  parameter int TAG_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_ie,
  input  logic [CMD_IO_WIDTH-1:0] cmd_in,
  output logic                    cq_cin_ready,
  output logic                    cmd_err,
  input  logic                    cmd_request,
  output logic                    cq_cout_ready,
  output logic                    cmd_oe,
  output logic [CMD_IO_WIDTH-1:0] cmd_out,
  input  logic                    op_we,
  input  logic [TAG_WIDTH-1:0]    op_index,
  input  logic [7:0]              cmd_op_status,
  input  logic                    query_ie,
  input  logic [TAG_WIDTH-1:0]    query_tag,
  output logic                    query_oe,
  output logic [CMD_IO_WIDTH-1:0] query_out
);

  localparam int BEATS  = CDB_WIDTH / CMD_IO_WIDTH;
  localparam int SLOT_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int WORDS  = CDB_WIDTH / 32;
  localparam int OCC_W  = SLOT_W + 1;

  localparam logic [7:0] ST_FREE       = 8'd0;
  localparam logic [7:0] ST_QUEUED     = 8'd1;
  localparam logic [7:0] ST_ISSUED     = 8'd2;
  localparam logic [7:0] ST_READ_DONE  = 8'd6;
  localparam logic [7:0] ST_WRITE_DONE = 8'd7;
  localparam logic [7:0] ST_TX_READY   = 8'd8;
  localparam logic [7:0] ST_READY2FREE = 8'd12;

  typedef enum logic [1:0] {IN_IDLE, IN_RECV, IN_COMMIT} in_state_t;
  typedef enum logic {EG_IDLE, EG_SEND} eg_state_t;
  typedef enum logic {QR_IDLE, QR_RESP} qr_state_t;

  in_state_t in_state, in_next;
  eg_state_t eg_state, eg_next;
  qr_state_t qr_state, qr_next;

  logic [CDB_WIDTH-1:0] slot_cdb [DEPTH];
  logic [7:0]           slot_st  [DEPTH];
  logic [SLOT_W-1:0]    fifo_mem [DEPTH];
  logic [SLOT_W:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ_count;

  logic [CDB_WIDTH-1:0] asm_q;
  logic [CNT_W-1:0]     in_cnt, eg_cnt, q_cnt;
  logic [SLOT_W-1:0]    eg_slot, q_slot;
  logic                 q_hit;

  logic                 in_beat_en, in_abort, accept, reject;
  logic [SLOT_W-1:0]    c_slot, head, op_slot, q_slot_in;
  logic                 c_collide, c_cksum_bad, fifo_full, fifo_empty;
  logic [31:0]          cksum;
  logic                 pop, op_valid, free_op, q_last, q_auto, free_q, q_hit_in;
  logic [TAG_WIDTH-1:0] q_stored_tag;
  logic                 unused_bits;

  assign unused_bits = ^op_index;

  // Ingress
  assign cq_cin_ready = (occ_count < OCC_W'(DEPTH)) && (in_state == IN_IDLE);
  assign in_beat_en   = cmd_ie && (((in_state == IN_IDLE) && cq_cin_ready) || (in_state == IN_RECV));

  always_comb begin
    in_next  = in_state;
    in_abort = 1'b0;
    case (in_state)
      IN_IDLE:   if (cmd_ie && cq_cin_ready) in_next = IN_RECV;
      IN_RECV: begin
        if (!cmd_ie) begin
          in_next  = IN_IDLE;
          in_abort = 1'b1;
        end else if (in_cnt == CNT_W'(BEATS - 1)) begin
          in_next = IN_COMMIT;
        end
      end
      IN_COMMIT: in_next = IN_IDLE;
      default:   in_next = IN_IDLE;
    endcase
  end

  always_comb begin
    cksum = '0;
    for (int i = 0; i < WORDS; i++) cksum = cksum ^ asm_q[i*32 +: 32];
  end

`ifdef HV_CMDQ_CHECKSUM_EN
  // XOR of every word, checksum word included, is zero for a good CDB.
  assign c_cksum_bad = (cksum != 32'd0);
`else
  assign c_cksum_bad = 1'b0;
`endif

  assign c_slot     = asm_q[8 +: SLOT_W];
  assign c_collide  = (slot_st[c_slot] != ST_FREE);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[SLOT_W] != rd_ptr[SLOT_W]) &&
                      (wr_ptr[SLOT_W-1:0] == rd_ptr[SLOT_W-1:0]);
  assign accept     = (in_state == IN_COMMIT) && !c_collide && !c_cksum_bad && !fifo_full;
  assign reject     = (in_state == IN_COMMIT) && !accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_state <= IN_IDLE;
      in_cnt   <= '0;
      cmd_err  <= 1'b0;
    end else begin
      in_state <= in_next;
      in_cnt   <= (in_next == IN_RECV) ? in_cnt + 1'b1 : '0;
      cmd_err  <= reject || in_abort;
    end
  end

  always_ff @(posedge clk) begin
    if (in_beat_en) asm_q[int'(in_cnt)*CMD_IO_WIDTH +: CMD_IO_WIDTH] <= cmd_in;
    if (accept) slot_cdb[c_slot] <= asm_q;
  end

  // Egress
  assign head          = fifo_mem[rd_ptr[SLOT_W-1:0]];
  assign cq_cout_ready = !fifo_empty && (eg_state == EG_IDLE);
  assign pop           = cmd_request && cq_cout_ready;

  always_comb begin
    eg_next = eg_state;
    case (eg_state)
      EG_IDLE: if (pop) eg_next = EG_SEND;
      EG_SEND: if (eg_cnt == CNT_W'(BEATS)) eg_next = EG_IDLE;
      default: eg_next = EG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      eg_state <= EG_IDLE;
      eg_cnt   <= '0;
      eg_slot  <= '0;
      rd_ptr   <= '0;
      cmd_oe   <= 1'b0;
      cmd_out  <= '0;
    end else begin
      eg_state <= eg_next;
      if (pop) begin
        eg_slot <= head;
        eg_cnt  <= CNT_W'(1);
        rd_ptr  <= rd_ptr + 1'b1;
        cmd_oe  <= 1'b1;
        cmd_out <= slot_cdb[head][CMD_IO_WIDTH-1:0];
      end else if (eg_state == EG_SEND) begin
        if (eg_cnt == CNT_W'(BEATS)) begin
          eg_cnt  <= '0;
          cmd_oe  <= 1'b0;
          cmd_out <= '0;
        end else begin
          eg_cnt  <= eg_cnt + 1'b1;
          cmd_out <= slot_cdb[eg_slot][int'(eg_cnt)*CMD_IO_WIDTH +: CMD_IO_WIDTH];
        end
      end
    end
  end

  // Query
  assign q_slot_in    = query_tag[SLOT_W-1:0];
  assign q_stored_tag = TAG_WIDTH'(slot_cdb[q_slot_in][15:8]);
  assign q_hit_in     = (slot_st[q_slot_in] != ST_FREE) && (q_stored_tag == query_tag);

  always_comb begin
    qr_next = qr_state;
    case (qr_state)
      QR_IDLE: if (query_ie) qr_next = QR_RESP;
      QR_RESP: if (q_cnt == CNT_W'(BEATS)) qr_next = QR_IDLE;
      default: qr_next = QR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      qr_state  <= QR_IDLE;
      q_cnt     <= '0;
      q_slot    <= '0;
      q_hit     <= 1'b0;
      query_oe  <= 1'b0;
      query_out <= '0;
    end else begin
      qr_state <= qr_next;
      if (qr_state == QR_IDLE && query_ie) begin
        q_slot    <= q_slot_in;
        q_hit     <= q_hit_in;
        q_cnt     <= CNT_W'(1);
        query_oe  <= 1'b1;
        query_out <= CMD_IO_WIDTH'({q_hit_in, slot_st[q_slot_in], 8'(query_tag)});
      end else if (qr_state == QR_RESP) begin
        if (q_cnt == CNT_W'(BEATS)) begin
          q_cnt     <= '0;
          query_oe  <= 1'b0;
          query_out <= '0;
        end else begin
          q_cnt     <= q_cnt + 1'b1;
          query_out <= q_hit ? slot_cdb[q_slot][int'(q_cnt)*CMD_IO_WIDTH +: CMD_IO_WIDTH]
                             : '0;
        end
      end
    end
  end

  // Slot status, issue FIFO and occupancy; a host status write on the same slot overrides the query auto-transition.
  assign op_slot  = op_index[SLOT_W-1:0];
  assign op_valid = op_we && (slot_st[op_slot] != ST_FREE);
  assign free_op  = op_valid && (cmd_op_status == ST_READY2FREE);
  assign q_last   = (qr_state == QR_RESP) && (q_cnt == CNT_W'(BEATS));
  assign q_auto   = q_last && q_hit && !(op_we && (op_slot == q_slot));
  assign free_q   = q_auto && (slot_st[q_slot] == ST_WRITE_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= ST_FREE;
      wr_ptr    <= '0;
      occ_count <= '0;
    end else begin
      if (pop && slot_st[head] != ST_FREE) slot_st[head] <= ST_ISSUED;
      if (q_auto) begin
        if (slot_st[q_slot] == ST_WRITE_DONE)     slot_st[q_slot] <= ST_FREE;
        else if (slot_st[q_slot] == ST_READ_DONE) slot_st[q_slot] <= ST_TX_READY;
      end
      if (op_valid) slot_st[op_slot] <= free_op ? ST_FREE : cmd_op_status;
      if (accept) begin
        slot_st[c_slot]                <= ST_QUEUED;
        fifo_mem[wr_ptr[SLOT_W-1:0]]   <= c_slot;
        wr_ptr                         <= wr_ptr + 1'b1;
      end
      occ_count <= occ_count + OCC_W'(accept) - OCC_W'(free_op) - OCC_W'(free_q);
    end
  end

endmodule

// File: tb/tb_hv_cmdq_param.sv
// Directed bench for hv_cmdq_param with default parameters (64-bit beats, 256-bit CDB, 8 slots).
module tb_hv_cmdq_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_ie;
  logic [63:0] cmd_in;
  logic        cq_cin_ready;
  logic        cmd_err;
  logic        cmd_request;
  logic        cq_cout_ready;
  logic        cmd_oe;
  logic [63:0] cmd_out;
  logic        op_we;
  logic [7:0]  op_index;
  logic [7:0]  cmd_op_status;
  logic        query_ie;
  logic [7:0]  query_tag;
  logic        query_oe;
  logic [63:0] query_out;

  int checks   = 0;
  int failures = 0;

  hv_cmdq_param dut (
    .clk(clk), .reset(reset),
    .cmd_ie(cmd_ie), .cmd_in(cmd_in), .cq_cin_ready(cq_cin_ready), .cmd_err(cmd_err),
    .cmd_request(cmd_request), .cq_cout_ready(cq_cout_ready), .cmd_oe(cmd_oe), .cmd_out(cmd_out),
    .op_we(op_we), .op_index(op_index), .cmd_op_status(cmd_op_status),
    .query_ie(query_ie), .query_tag(query_tag), .query_oe(query_oe), .query_out(query_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_cdb(input logic [7:0] op, input logic [7:0] tag,
                                            input logic [7:0] seed);
    logic [31:0]  w [8];
    logic [31:0]  x;
    logic [255:0] r;
    w[0] = {seed, 8'h5A, tag, op};
    for (int i = 1; i < 8; i++) w[i] = {seed ^ 8'(i), 8'(i * 17), 8'hC3 ^ seed, 8'(i)};
    x = '0;
    for (int i = 0; i < 8; i++) if (i != 4) x = x ^ w[i];
    w[4] = x;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic wait_cin();
    for (int i = 0; i < 64 && !cq_cin_ready; i++) @(negedge clk);
    check("cin_wait", cq_cin_ready, 1);
  endtask

  task automatic wait_cout();
    for (int i = 0; i < 64 && !cq_cout_ready; i++) @(negedge clk);
    check("cout_wait", cq_cout_ready, 1);
  endtask

  task automatic send_cdb(input logic [255:0] cdb, input int nbeats, input logic exp_err);
    wait_cin();
    for (int b = 0; b < nbeats; b++) begin
      cmd_ie = 1'b1;
      cmd_in = cdb[b*64 +: 64];
      @(negedge clk);
    end
    cmd_ie = 1'b0;
    cmd_in = '0;
    check("cin_busy", cq_cin_ready, 0);
    @(negedge clk);
    check("cmd_err", cmd_err, exp_err);
  endtask

  task automatic do_request(input logic [255:0] exp_cdb, input string nm);
    wait_cout();
    cmd_request = 1'b1;
    @(negedge clk);
    cmd_request = 1'b0;
    check({nm, "_cout_busy"}, cq_cout_ready, 0);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("%s_oe%0d", nm, b), cmd_oe, 1);
      check($sformatf("%s_beat%0d", nm, b), cmd_out, exp_cdb[b*64 +: 64]);
      @(negedge clk);
    end
    check({nm, "_oe_fall"}, cmd_oe, 0);
  endtask

  task automatic do_query(input logic [7:0] tag, input logic [63:0] exp_b0,
                          input logic [255:0] exp_cdb, input logic hit, input string nm);
    query_ie  = 1'b1;
    query_tag = tag;
    @(negedge clk);
    query_ie = 1'b0;
    check({nm, "_qoe"}, query_oe, 1);
    check({nm, "_b0"}, query_out, exp_b0);
    @(negedge clk);
    for (int b = 1; b < 4; b++) begin
      check($sformatf("%s_b%0d", nm, b), query_out, hit ? exp_cdb[b*64 +: 64] : 64'd0);
      @(negedge clk);
    end
    check({nm, "_qoe_fall"}, query_oe, 0);
  endtask

  task automatic op_write(input logic [7:0] tag, input logic [7:0] st);
    op_we         = 1'b1;
    op_index      = tag;
    cmd_op_status = st;
    @(negedge clk);
    op_we = 1'b0;
  endtask

  // Scoreboard of CDBs expected on the egress port, in issue order.
  logic [255:0] exp_q[$];
  logic [255:0] cdb_a, cdb_b, cdb_c, cdb_d, cdb_e, cdb_8, cdb_p, exp_cdb;
  logic [7:0]   occ;
  logic         e_err;
  int           exp_cnt;

  initial begin
    reset = 1'b0; cmd_ie = 1'b0; cmd_in = '0; cmd_request = 1'b0;
    op_we = 1'b0; op_index = '0; cmd_op_status = '0; query_ie = 1'b0; query_tag = '0;
    cdb_a = make_cdb(8'h40, 8'd0, 8'h11);
    cdb_b = make_cdb(8'h40, 8'd1, 8'h22);
    cdb_c = make_cdb(8'h40, 8'd2, 8'h33);
    cdb_d = make_cdb(8'h30, 8'd3, 8'h44);
    cdb_e = make_cdb(8'h40, 8'd4, 8'h55);
    cdb_e[128] = ~cdb_e[128];
    cdb_8 = make_cdb(8'h40, 8'd8, 8'h66);
    cdb_p = make_cdb(8'h40, 8'd7, 8'h77);

    repeat (3) @(negedge clk);
    check("rst_cmd_oe", cmd_oe, 0);
    check("rst_query_oe", query_oe, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_cout_ready", cq_cout_ready, 0);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_query_out", query_out, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cin_ready", cq_cin_ready, 1);

    // Three writes, then issue them in order.
    send_cdb(cdb_a, 4, 1'b0);
    check("cout_after_first_commit", cq_cout_ready, 1);
    exp_q.push_back(cdb_a);
    send_cdb(cdb_b, 4, 1'b0);
    exp_q.push_back(cdb_b);
    send_cdb(cdb_c, 4, 1'b0);
    exp_q.push_back(cdb_c);
    exp_cnt = 3;
    check("count_3", dut.occ_count, 64'(exp_cnt));
    while (exp_q.size() > 0) begin
      exp_cdb = exp_q.pop_front();
      do_request(exp_cdb, "issue");
    end
    check("cout_empty", cq_cout_ready, 0);
    cmd_request = 1'b1;
    @(negedge clk);
    cmd_request = 1'b0;
    check("ignored_request", cmd_oe, 0);

    // WRITE_DONE query frees the slot.
    op_write(8'd0, 8'd7);
    do_query(8'd0, 64'h0000_0000_0001_0700, cdb_a, 1'b1, "q_wd");
    exp_cnt = 2;
    check("count_after_wd", dut.occ_count, 64'(exp_cnt));
    do_query(8'd0, 64'h0, cdb_a, 1'b0, "q_freed");

    // READ path: READ_DONE -> TX_READY -> READY2FREE.
    send_cdb(cdb_d, 4, 1'b0);
    do_request(cdb_d, "issue_d");
    op_write(8'd3, 8'd6);
    do_query(8'd3, 64'h0000_0000_0001_0603, cdb_d, 1'b1, "q_rd");
    do_query(8'd3, 64'h0000_0000_0001_0803, cdb_d, 1'b1, "q_txr");
    check("count_txr", dut.occ_count, 64'd3);
    op_write(8'd3, 8'd12);
    do_query(8'd3, 64'h0000_0000_0000_0003, cdb_d, 1'b0, "q_r2f");
    check("count_r2f", dut.occ_count, 64'(exp_cnt));

    // Corrupted checksum.
`ifdef HV_CMDQ_CHECKSUM_EN
    e_err = 1'b1;
`else
    e_err = 1'b0;
`endif
    send_cdb(cdb_e, 4, e_err);
    occ = 8'b0000_0110;
    if (!e_err) begin
      occ[4] = 1'b1;
      exp_cnt++;
    end
    check("count_cksum", dut.occ_count, 64'(exp_cnt));

    // Fill every remaining slot.
    for (int t = 0; t < 8; t++) begin
      if (!occ[t]) begin
        send_cdb(make_cdb(8'h40, 8'(t), 8'(8'h80 + t)), 4, 1'b0);
        exp_cnt++;
      end
    end
    check("count_full", dut.occ_count, 64'(exp_cnt));
    check("cin_full", cq_cin_ready, 0);
    op_write(8'd1, 8'd12);
    check("cin_after_free", cq_cin_ready, 1);
    send_cdb(cdb_8, 4, 1'b1);
    check("count_collide", dut.occ_count, 64'd7);
    op_write(8'd0, 8'd12);
    send_cdb(cdb_8, 4, 1'b0);
    check("count_tag8", dut.occ_count, 64'd7);
    do_query(8'd8, 64'h0000_0000_0001_0108, cdb_8, 1'b1, "q_tag8");
    do_query(8'd0, 64'h0000_0000_0000_0100, cdb_8, 1'b0, "q_tag0_miss");

    // Partial CDB on slot 7.
    op_write(8'd7, 8'd12);
    send_cdb(cdb_p, 3, 1'b1);
    check("count_partial", dut.occ_count, 64'd6);
    do_query(8'd7, 64'h0000_0000_0000_0007, cdb_p, 1'b0, "q_partial");

    // Reset in the middle of an egress burst.
    wait_cout();
    cmd_request = 1'b1;
    @(negedge clk);
    cmd_request = 1'b0;
    check("mid_oe", cmd_oe, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_oe", cmd_oe, 0);
    check("mid_rst_out", cmd_out, 0);
    check("mid_rst_cout", cq_cout_ready, 0);
    check("mid_rst_err", cmd_err, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_cin", cq_cin_ready, 1);
    check("post_rst_cout", cq_cout_ready, 0);
    check("post_rst_count", dut.occ_count, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
